// File: rtl/mu0_cpu.sv
// -----------------------------------------------------------------------------
// mu0_cpu
//
// Minimal MU0 accumulator processor. Each instruction takes two cycles: a
// FETCH cycle that reads the instruction word at PC, then an EXEC cycle that
// either accesses memory at the operand address or updates PC. An STP
// instruction parks the core in HALT until the next reset.
//
// Instruction word: [15:12] opcode, [11:0] operand address S.
//   0 LDA  ACC <= mem[S]          4 JMP  PC <= S
//   1 STA  mem[S] <= ACC          5 JGE  PC <= S if ACC >= 0 (signed)
//   2 ADD  ACC <= ACC + mem[S]    6 JNE  PC <= S if ACC != 0
//   3 SUB  ACC <= ACC - mem[S]    7 STP  halt
//   8-F    no operation
//
// Parameters
//   RESET_PC  program counter value loaded while Reset is low
//
// Ports
//   Clk     in   1   clock, all state updates on the rising edge
//   Reset   in   1   synchronous active-low reset
//   Din     in  16   read data for the word at Addr (asynchronous-read memory)
//   Wr      out  1   write strobe; memory stores Dout at Addr on the edge
//   Addr    out 12   memory word address
//   Dout    out 16   write data, always the accumulator
//   Halted  out  1   high once STP has executed
// -----------------------------------------------------------------------------
module mu0_cpu #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Din,
  output logic        Wr,
  output logic [11:0] Addr,
  output logic [15:0] Dout,
  output logic        Halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_STA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_JMP = 4'h4,
    OP_JGE = 4'h5,
    OP_JNE = 4'h6,
    OP_STP = 4'h7
  } op_t;

  state_t      state;
  logic [15:0] acc;
  logic [11:0] pc;
  logic [15:0] ir;

  op_t         opcode;
  logic [11:0] operand;
  logic        mem_op;

  assign opcode  = op_t'(ir[15:12]);
  assign operand = ir[11:0];
  // Opcodes 0-3 are the only ones that use the operand as a data address.
  assign mem_op  = (ir[15:14] == 2'b00);

  // ---------------------------------------------------------------------------
  // Memory interface
  // ---------------------------------------------------------------------------

  // NOTE: every output of a combinational block gets a default before the
  // case so that no path leaves it unassigned and no latch is inferred.
  always_comb begin
    Addr = pc;
    if (state == EXEC && mem_op) begin
      Addr = operand;
    end
  end

  // Gating with Reset aborts a store that is in its EXEC cycle when reset
  // arrives, so memory is never written on a reset edge.
  assign Wr     = Reset && (state == EXEC) && (opcode == OP_STA);
  assign Dout   = acc;
  assign Halted = (state == HALT);

  // ---------------------------------------------------------------------------
  // Processor state
  // ---------------------------------------------------------------------------

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the branch tests below therefore see ACC as
  // it was at the start of the EXEC cycle.
  always_ff @(posedge Clk) begin
    // NOTE: reset is synchronous and checked first, so it overrides every
    // state, including HALT, which can only be left this way.
    if (!Reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      acc   <= '0;
      ir    <= '0;
    end else begin
      case (state)
        FETCH: begin
          ir    <= Din;
          pc    <= pc + 12'd1;   // wraps FFF -> 000
          state <= EXEC;
        end

        EXEC: begin
          state <= FETCH;
          case (opcode)
            OP_LDA: acc <= Din;
            OP_STA: ;            // the write itself is the Wr strobe
            OP_ADD: acc <= acc + Din;
            OP_SUB: acc <= acc - Din;
            OP_JMP: pc  <= operand;
            OP_JGE: if (!acc[15])     pc <= operand;
            OP_JNE: if (acc != 16'h0) pc <= operand;
            OP_STP: state <= HALT;
            default: ;           // 8-F: no operation
          endcase
        end

        HALT: ;                  // everything frozen until reset

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mu0_cpu.sv
// -----------------------------------------------------------------------------
// tb_mu0_cpu
//
// Drives mu0_cpu against a 4K x 16 asynchronous-read memory model. Expected
// memory writes are queued by each scenario before the program runs; a
// monitor pops and compares them whenever the core raises Wr. ACC is observed
// on Dout, PC on Addr during FETCH and HALT cycles.
// -----------------------------------------------------------------------------
module tb_mu0_cpu;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Din;
  logic        Wr;
  logic [11:0] Addr;
  logic [15:0] Dout;
  logic        Halted;

  logic [15:0] mem [0:4095];

  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_wr[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  wr_count = 0;

  mu0_cpu dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Din    (Din),
    .Wr     (Wr),
    .Addr   (Addr),
    .Dout   (Dout),
    .Halted (Halted)
  );

  always #5 Clk = ~Clk;

  assign Din = mem[Addr];

  always @(posedge Clk) begin
    if (Wr === 1'b1) mem[Addr] <= Dout;
  end

  // Write monitor: samples shortly after each falling edge, after any
  // stimulus change made on that edge has settled.
  always @(negedge Clk) begin
    wr_t e;
    #2;
    if (Reset === 1'b0) begin
      n_checks++;
      if (Wr !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_during_reset: Wr=%b required 0", Wr);
      end
    end else if (Wr === 1'b1) begin
      wr_count++;
      n_checks++;
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%h data=%h, no write expected", Addr, Dout);
      end else begin
        e = exp_wr.pop_front();
        if (Addr !== e.addr || Dout !== e.data) begin
          n_fail++;
          $display("FAIL write_data: got addr=%h data=%h required addr=%h data=%h",
                   Addr, Dout, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Stimulus utilities
  // ---------------------------------------------------------------------------

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Leaves Reset low after one rising edge has sampled it.
  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  // Called on a falling edge; the next rising edge is the first fetch.
  task automatic release_reset();
    Reset = 1'b1;
  endtask

  task automatic run_to_halt(output int cyc);
    cyc = 0;
    while (Halted !== 1'b1 && cyc < 200) begin
      @(negedge Clk);
      cyc++;
    end
    n_checks++;
    if (Halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_timeout: Halted=%b after %0d cycles, required 1", Halted, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------

  task automatic test_reset();
    clear_mem();
    mem[0] = 16'h1000;
    Reset = 1'b0;
    apply_reset();
    n_checks++; if (Addr !== 12'h000) begin n_fail++; $display("FAIL reset_addr: got %h required %h", Addr, 12'h000); end
    n_checks++; if (Dout !== 16'h0000) begin n_fail++; $display("FAIL reset_dout: got %h required %h", Dout, 16'h0000); end
    n_checks++; if (Wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b required 0", Wr); end
    n_checks++; if (Halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b required 0", Halted); end
    step(1);
    n_checks++; if (Addr !== 12'h000) begin n_fail++; $display("FAIL reset_hold_addr: got %h required %h", Addr, 12'h000); end
  endtask

  task automatic test_load_store();
    int cyc;
    int w0;
    clear_mem();
    mem[0] = 16'h0004; mem[1] = 16'h2005; mem[2] = 16'h1006; mem[3] = 16'h7000;
    mem[4] = 16'h0003; mem[5] = 16'h0004;
    exp_wr.push_back('{addr: 12'h006, data: 16'h0007});
    w0 = wr_count;
    release_reset();
    run_to_halt(cyc);
    n_checks++; if (cyc != 8) begin n_fail++; $display("FAIL ls_cycles: got %0d required 8", cyc); end
    n_checks++; if (Dout !== 16'h0007) begin n_fail++; $display("FAIL ls_acc: got %h required %h", Dout, 16'h0007); end
    n_checks++; if (mem[6] !== 16'h0007) begin n_fail++; $display("FAIL ls_mem6: got %h required %h", mem[6], 16'h0007); end
    n_checks++; if (wr_count - w0 != 1) begin n_fail++; $display("FAIL ls_wr_pulses: got %0d required 1", wr_count - w0); end
    n_checks++; if (exp_wr.size() != 0) begin n_fail++; $display("FAIL ls_pending_writes: got %0d required 0", exp_wr.size()); end
    n_checks++; if (Addr !== 12'h004) begin n_fail++; $display("FAIL ls_halt_pc: got %h required %h", Addr, 12'h004); end
    step(3);
    n_checks++; if (Addr !== 12'h004) begin n_fail++; $display("FAIL ls_pc_frozen: got %h required %h", Addr, 12'h004); end
    n_checks++; if (Dout !== 16'h0007) begin n_fail++; $display("FAIL ls_acc_frozen: got %h required %h", Dout, 16'h0007); end
    n_checks++; if (Halted !== 1'b1) begin n_fail++; $display("FAIL ls_halted_held: got %b required 1", Halted); end
    apply_reset();
  endtask

  task automatic test_sub_jge(input logic [15:0] b, input logic [15:0] exp_acc,
                              input logic [11:0] exp_pc);
    int cyc;
    clear_mem();
    mem[0] = 16'h0010; mem[1] = 16'h3011; mem[2] = 16'h5005;
    mem[3] = 16'h7000; mem[5] = 16'h7000;
    mem[16'h010] = 16'h0002; mem[16'h011] = b;
    release_reset();
    step(6);
    n_checks++; if (Addr !== exp_pc) begin n_fail++; $display("FAIL jge_next_fetch b=%h: got %h required %h", b, Addr, exp_pc); end
    n_checks++; if (Dout !== exp_acc) begin n_fail++; $display("FAIL jge_acc b=%h: got %h required %h", b, Dout, exp_acc); end
    n_checks++; if (Halted !== 1'b0) begin n_fail++; $display("FAIL jge_not_halted b=%h: got %b required 0", b, Halted); end
    run_to_halt(cyc);
    n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL jge_stp_cycles b=%h: got %0d required 2", b, cyc); end
    n_checks++; if (Addr !== exp_pc + 12'd1) begin n_fail++; $display("FAIL jge_halt_pc b=%h: got %h required %h", b, Addr, exp_pc + 12'd1); end
    apply_reset();
  endtask

  task automatic test_jne_countdown();
    int cyc;
    int subs;
    int w0;
    clear_mem();
    mem[0] = 16'h0020; mem[1] = 16'h3021; mem[2] = 16'h6001; mem[3] = 16'h7000;
    mem[16'h020] = 16'h0003; mem[16'h021] = 16'h0001;
    w0 = wr_count;
    subs = 0;
    cyc = 0;
    release_reset();
    while (Halted !== 1'b1 && cyc < 100) begin
      @(negedge Clk);
      cyc++;
      if (Addr === 12'h021) subs++;
    end
    n_checks++; if (Halted !== 1'b1) begin n_fail++; $display("FAIL jne_halt_timeout: Halted=%b required 1", Halted); end
    n_checks++; if (subs != 3) begin n_fail++; $display("FAIL jne_sub_count: got %0d required 3", subs); end
    n_checks++; if (Dout !== 16'h0000) begin n_fail++; $display("FAIL jne_acc: got %h required %h", Dout, 16'h0000); end
    n_checks++; if (cyc != 16) begin n_fail++; $display("FAIL jne_cycles: got %0d required 16", cyc); end
    n_checks++; if (wr_count != w0) begin n_fail++; $display("FAIL jne_no_write: got %0d pulses required 0", wr_count - w0); end
    n_checks++; if (Addr !== 12'h004) begin n_fail++; $display("FAIL jne_halt_pc: got %h required %h", Addr, 12'h004); end
    apply_reset();
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[0] = 16'h0030; mem[1] = 16'h2031; mem[2] = 16'h0032; mem[3] = 16'h2031;
    mem[4] = 16'h4FFF; mem[12'hFFF] = 16'h0033;
    mem[16'h030] = 16'h7FFF; mem[16'h031] = 16'h0001;
    mem[16'h032] = 16'hFFFF; mem[16'h033] = 16'h1234;
    release_reset();
    step(4);
    n_checks++; if (Dout !== 16'h8000) begin n_fail++; $display("FAIL wrap_add_7fff: got %h required %h", Dout, 16'h8000); end
    step(4);
    n_checks++; if (Dout !== 16'h0000) begin n_fail++; $display("FAIL wrap_add_ffff: got %h required %h", Dout, 16'h0000); end
    step(2);
    n_checks++; if (Addr !== 12'hFFF) begin n_fail++; $display("FAIL wrap_jmp_fff: got %h required %h", Addr, 12'hFFF); end
    step(2);
    n_checks++; if (Addr !== 12'h000) begin n_fail++; $display("FAIL wrap_pc: got %h required %h", Addr, 12'h000); end
    n_checks++; if (Dout !== 16'h1234) begin n_fail++; $display("FAIL wrap_exec_fff: got %h required %h", Dout, 16'h1234); end
    apply_reset();
  endtask

  task automatic test_mid_reset();
    int cyc;
    clear_mem();
    mem[0] = 16'h0040; mem[1] = 16'h1041; mem[2] = 16'h7000;
    mem[16'h040] = 16'h5555; mem[16'h041] = 16'hAAAA;
    release_reset();
    step(3);                      // now in the EXEC cycle of STA
    Reset = 1'b0;
    #1;
    n_checks++; if (Wr !== 1'b0) begin n_fail++; $display("FAIL mid_wr_forced: got %b required 0", Wr); end
    @(negedge Clk);
    n_checks++; if (mem[16'h041] !== 16'hAAAA) begin n_fail++; $display("FAIL mid_mem_kept: got %h required %h", mem[16'h041], 16'hAAAA); end
    n_checks++; if (Addr !== 12'h000) begin n_fail++; $display("FAIL mid_pc: got %h required %h", Addr, 12'h000); end
    n_checks++; if (Dout !== 16'h0000) begin n_fail++; $display("FAIL mid_acc: got %h required %h", Dout, 16'h0000); end
    n_checks++; if (Halted !== 1'b0) begin n_fail++; $display("FAIL mid_halted: got %b required 0", Halted); end

    exp_wr.push_back('{addr: 12'h041, data: 16'h5555});
    release_reset();
    run_to_halt(cyc);
    n_checks++; if (cyc != 6) begin n_fail++; $display("FAIL halt_run_cycles: got %0d required 6", cyc); end
    n_checks++; if (mem[16'h041] !== 16'h5555) begin n_fail++; $display("FAIL halt_run_store: got %h required %h", mem[16'h041], 16'h5555); end
    Reset = 1'b0;
    @(negedge Clk);
    n_checks++; if (Halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset_clear: got %b required 0", Halted); end
    n_checks++; if (Addr !== 12'h000) begin n_fail++; $display("FAIL halt_reset_pc: got %h required %h", Addr, 12'h000); end
    n_checks++; if (Dout !== 16'h0000) begin n_fail++; $display("FAIL halt_reset_acc: got %h required %h", Dout, 16'h0000); end
    release_reset();
    step(1);
    n_checks++; if (Addr !== 12'h040) begin n_fail++; $display("FAIL restart_exec_addr: got %h required %h", Addr, 12'h040); end
    step(1);
    n_checks++; if (Dout !== 16'h5555) begin n_fail++; $display("FAIL restart_acc: got %h required %h", Dout, 16'h5555); end
    n_checks++; if (Addr !== 12'h001) begin n_fail++; $display("FAIL restart_pc: got %h required %h", Addr, 12'h001); end
    apply_reset();
  endtask

  task automatic test_undefined_op();
    int cyc;
    int w0;
    clear_mem();
    mem[0] = 16'h0050; mem[1] = 16'h8123; mem[2] = 16'h7000;
    mem[16'h050] = 16'h1357; mem[16'h123] = 16'hFFFF;
    w0 = wr_count;
    release_reset();
    step(2);
    n_checks++; if (Addr !== 12'h001) begin n_fail++; $display("FAIL undef_fetch_pc: got %h required %h", Addr, 12'h001); end
    step(1);
    n_checks++; if (Addr !== 12'h002) begin n_fail++; $display("FAIL undef_exec_addr: got %h required %h", Addr, 12'h002); end
    n_checks++; if (Wr !== 1'b0) begin n_fail++; $display("FAIL undef_wr: got %b required 0", Wr); end
    step(1);
    n_checks++; if (Dout !== 16'h1357) begin n_fail++; $display("FAIL undef_acc: got %h required %h", Dout, 16'h1357); end
    n_checks++; if (Addr !== 12'h002) begin n_fail++; $display("FAIL undef_next_pc: got %h required %h", Addr, 12'h002); end
    run_to_halt(cyc);
    n_checks++; if (Addr !== 12'h003) begin n_fail++; $display("FAIL undef_halt_pc: got %h required %h", Addr, 12'h003); end
    n_checks++; if (wr_count != w0) begin n_fail++; $display("FAIL undef_no_write: got %0d pulses required 0", wr_count - w0); end
    apply_reset();
  endtask

  initial begin
    Reset = 1'b0;
    test_reset();
    test_load_store();
    test_sub_jge(16'h0003, 16'hFFFF, 12'h003);
    test_sub_jge(16'h0001, 16'h0001, 12'h005);
    test_jne_countdown();
    test_wrap();
    test_mid_reset();
    test_undefined_op();
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mu0_cpu.md
MU0_CPU -- requirements
Module: mu0_cpu

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 12'h000, the program-counter value loaded on reset.
REQ-002 Clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 Reset  input  1  reset, synchronous and active-low: 0 = reset, sampled on the rising edge of Clk.
REQ-004 Din  input  16  memory read data for the word at Addr, valid in the same cycle (asynchronous-read memory).
REQ-005 Wr  output  1  memory write strobe; memory writes Dout to Addr on the rising edge where Wr=1.
REQ-006 Addr  output  12  memory word address.
REQ-007 Dout  output  16  memory write data; always equal to ACC.
REQ-008 Halted  output  1  high once STP has executed.

Function
REQ-009 Internal state SHALL be: ACC (16 bits), PC (12 bits), IR (16 bits), and a state register with states FETCH, EXEC and HALT.
REQ-010 Instruction format SHALL be IR[15:12] = opcode and IR[11:0] = operand address S.
REQ-011 FETCH cycle:
- Addr=PC, Wr=0
- on the edge: IR<=Din, PC<=PC+1, state<=EXEC.
REQ-012 EXEC cycle: Addr=S for opcodes 0-3; otherwise Addr=PC.
REQ-013 Opcodes 0-3 (memory accesses):
- 0 LDA: ACC<=Din
- 1 STA: Wr=1 for this cycle only, Dout=ACC
- 2 ADD: ACC<=ACC+Din
- 3 SUB: ACC<=ACC-Din
REQ-014 Opcodes 4-6 (jumps):
- 4 JMP: PC<=S
- 5 JGE: PC<=S if ACC[15]=0, else no change
- 6 JNE: PC<=S if ACC!=0, else no change
REQ-015 Opcodes 7-F:
- 7 STP: state<=HALT
- 8-F: no operation.
REQ-016 After EXEC, state SHALL return to FETCH, except after STP.
REQ-017 Every instruction SHALL take exactly 2 cycles, with no memory wait states.
REQ-018 Arithmetic SHALL be 16-bit two's complement, modulo 2^16, with no flags and no overflow trap.
REQ-019 PC increment SHALL wrap from 12'hFFF to 12'h000.
REQ-020 JGE/JNE SHALL test the ACC value as it stands at the start of the EXEC cycle.
REQ-021 HALT state:
- Halted=1, Wr=0, Addr=PC
- ACC, PC and IR frozen
- exit only through reset.
REQ-022 Halted SHALL be 0 in FETCH and EXEC, and SHALL rise in the cycle after STP's EXEC cycle.
REQ-023 Wr SHALL be 1 only in the EXEC cycle of STA, with Reset=1; it is driven combinationally from state and IR.

Reset
REQ-024 On a rising edge with Reset=0, the block SHALL load PC<=RESET_PC, ACC<=0, IR<=0 and state<=FETCH, so Halted=0.
REQ-025 While Reset=0, Wr SHALL be forced to 0 combinationally, so a store in progress when reset asserts is aborted.
REQ-026 Reset SHALL take priority over every other update, in any state (FETCH, EXEC or HALT).
REQ-027 After the first Reset=0 edge the outputs SHALL be: Addr=RESET_PC, Dout=0, Wr=0, Halted=0.
REQ-028 The first fetch SHALL occur on the first rising edge with Reset=1.

Verification
REQ-029 Load/store/halt:
- memory 000:0004, 001:2005, 002:1006, 003:7000, 004:0003, 005:0004
- release reset
- response: ACC=0007; mem[006]=0007 written with exactly one Wr pulse; Halted=1 after exactly 8 cycles; PC frozen at 004.
REQ-030 Subtract and JGE:
- program LDA a, SUB b, JGE to an STP with a=0002, b=0003
- response: ACC=FFFF, jump not taken, PC=003 at the next fetch.
- repeat with b=0001: ACC=0001, jump taken.
REQ-031 JNE countdown:
- ACC=0003, loop of SUB one / JNE loop
- response: exactly 3 SUB executions; ACC=0000 at fall-through; no Wr asserted.
REQ-032 Wrap:
- ADD 7FFF+0001 -> ACC=8000
- ADD FFFF+0001 -> ACC=0000
- executing at PC=FFF wraps the next fetch to 000.
REQ-033 Mid-instruction reset:
- drive Reset=0 during the EXEC cycle of STA
- response: Wr=0 that cycle, memory unchanged; after the edge PC=000, ACC=0000, Halted=0.
- reset while HALT: Halted clears and execution restarts at 000.
REQ-034 Undefined opcode:
- an instruction word of 8123
- response: no state change except PC+1; Wr=0 throughout.
